mer_meas_ctrl: RTL
==================

MER_MEAS_CTRL -- requirements
Module: mer_meas_ctrl

Interface
REQ-001 Parameter SETTLE_SYMS, default 16: symbols discarded after an accumulator clear before measurement starts (range 1..255).
REQ-002 Parameter WIN_LOG2, default 10: the measurement window is 2^WIN_LOG2 symbols (range 4..16).
REQ-003 clk  in  1  single system clock; every register in the block is clocked on its rising edge.
REQ-004 reset  in  1  asynchronous, active-low reset.
REQ-005 sym_clk_en  in  1  one-clk symbol strobe; inputs are sampled only when it is high.
REQ-006 start  in  1  single-cycle request to run one measurement.
REQ-007 abort  in  1  synchronous request to cancel a running measurement.
REQ-008 sym_error  in  1  symbol-decision mismatch flag, valid with sym_clk_en.
REQ-009 error  in  18  signed slicer error, valid with sym_clk_en.
REQ-010 clear_accum  out  1  one-clk pulse that clears the downstream accumulators.
REQ-011 busy  out  1  high in every state except IDLE.
REQ-012 done  out  1  one-clk pulse when new results are latched.
REQ-013 err_count  out  WIN_LOG2+1  symbol errors counted in the last completed window.
REQ-014 mean_sq_err  out  36  unsigned mean of error^2 over the last completed window.

Function
REQ-015 The FSM SHALL use the states IDLE, CLEAR, SETTLE, MEASURE and DONE.
REQ-016 IDLE: start=1 and abort=0 -> CLEAR; start is ignored in every other state.
REQ-017 CLEAR: clear_accum=1 for exactly one clk; symbol counter and working accumulators zeroed; -> SETTLE next clk.
REQ-018 SETTLE: counter increments on each sym_clk_en; on the SETTLE_SYMS-th strobe -> MEASURE, counter zeroed; that strobe's data is not accumulated.
REQ-019 MEASURE: on each sym_clk_en, add error*error (36-bit unsigned, exact) into an accumulator of 36+WIN_LOG2 bits; increment the working error count if sym_error=1; increment the symbol counter.
REQ-020 On the strobe that brings the symbol count to 2^WIN_LOG2, that symbol is included; -> DONE.
REQ-021 DONE: err_count <= working count; mean_sq_err <= accumulator bits [35+WIN_LOG2:WIN_LOG2] (truncating divide); done=1 for one clk; -> IDLE.
REQ-022 Strobes arriving in IDLE, CLEAR or DONE SHALL be ignored.
REQ-023 abort=1 in CLEAR, SETTLE or MEASURE -> IDLE next clk; results unchanged; no done pulse.
REQ-024 abort and start high together in IDLE: abort wins; remain in IDLE.
REQ-025 abort in DONE is ignored; results latch and done pulses.
REQ-026 Results SHALL hold their values until the next DONE.
REQ-027 The error count cannot overflow: its maximum, 2^WIN_LOG2, fits in WIN_LOG2+1 bits.
REQ-028 Latency from start to done = 2 + SETTLE_SYMS + 2^WIN_LOG2 strobes + 1 clk.

Reset
REQ-029 reset low SHALL force IDLE immediately: clear_accum=0, busy=0, done=0, err_count=0, mean_sq_err=0, all counters and accumulators 0.
REQ-030 Reset asserted mid-measurement discards the measurement; after release the block waits in IDLE for start.

Structure
REQ-031 Package mer_ctrl_pkg SHALL hold the state enum, the SETTLE_SYMS and WIN_LOG2 default constants, and the 36-bit square-width constant.
REQ-032 The squarer and accumulator SHALL be a sub-module err_pow_accum with inputs clr, en and error and output acc; the FSM and counters stay in the top module.

Verification
REQ-033 Run with SETTLE_SYMS=16, WIN_LOG2=10, error=+1000 constant, sym_error=0 -> done once; mean_sq_err=1000000; err_count=0; busy high from start until the done clk.
REQ-034 Run with error=-131072 constant and sym_error=1 on every strobe -> mean_sq_err=17179869184; err_count=1024; no overflow.
REQ-035 Run with sym_error=1 only on the first 16 settle strobes and the last window strobe -> err_count=1, proving the settle/window boundaries.
REQ-036 abort at MEASURE strobe 500 after a prior result of 1000000 -> IDLE; no done; mean_sq_err stays 1000000; a following start completes normally.
REQ-037 start while busy, and start+abort together in IDLE -> both ignored; exactly one clear_accum pulse per accepted start.
REQ-038 reset low mid-SETTLE -> all outputs 0 asynchronously; after release, no activity until start.

Source files
------------

// File: rtl/mer_ctrl_pkg.sv
// mer_ctrl_pkg: shared FSM state type and sizing constants for the MER measurement controller.
package mer_ctrl_pkg;
  typedef enum logic [2:0] {IDLE, CLEAR, SETTLE, MEASURE, DONE} state_e;
  localparam int SETTLE_SYMS_DEF = 16;
  localparam int WIN_LOG2_DEF = 10;
  localparam int SQ_W = 36;
endpackage

// File: rtl/err_pow_accum.sv
// err_pow_accum: exact squarer of the signed slicer error feeding a wide power accumulator.
module err_pow_accum
  import mer_ctrl_pkg::*;
#(
  parameter int WIN_LOG2 = WIN_LOG2_DEF
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       clr_i,
  input  logic                       en_i,
  input  logic signed [17:0]         error_i,
  output logic [SQ_W+WIN_LOG2-1:0]   acc_o
);
  logic signed [SQ_W-1:0] err_x;
  logic [SQ_W-1:0] sq;
  logic [SQ_W+WIN_LOG2-1:0] acc_q, acc_d;
  // The square of an 18-bit signed value is below 2^35, so the 36-bit product is exact and non-negative.
  always_comb begin
    err_x = SQ_W'(error_i);
    sq = SQ_W'(err_x * err_x);
    acc_d = clr_i ? '0 : en_i ? acc_q + {{WIN_LOG2{1'b0}}, sq} : acc_q;
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) acc_q <= '0;
    else acc_q <= acc_d;
  end
  assign acc_o = acc_q;
endmodule

// File: rtl/mer_meas_ctrl.sv
// mer_meas_ctrl: sequences clear, settle and one 2^WIN_LOG2-symbol window, then latches
// the symbol error count and the mean squared slicer error.
module mer_meas_ctrl
  import mer_ctrl_pkg::*;
#(
  parameter int SETTLE_SYMS = SETTLE_SYMS_DEF,
  parameter int WIN_LOG2 = WIN_LOG2_DEF
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                sym_clk_en_i,
  input  logic                start_i,
  input  logic                abort_i,
  input  logic                sym_error_i,
  input  logic signed [17:0]  error_i,
  output logic                clear_accum_o,
  output logic                busy_o,
  output logic                done_o,
  output logic [WIN_LOG2:0]   err_count_o,
  output logic [SQ_W-1:0]     mean_sq_err_o
);
  localparam int CW = WIN_LOG2 > 8 ? WIN_LOG2 : 8;
  localparam int EW = WIN_LOG2 + 1;
  localparam logic [CW-1:0] SET_LAST = CW'(SETTLE_SYMS - 1);
  localparam logic [CW-1:0] WIN_LAST = CW'((1 << WIN_LOG2) - 1);
  state_e state_q;
  logic [CW-1:0] cnt_q;
  logic [EW-1:0] err_q, err_count_q;
  logic [SQ_W-1:0] mse_q;
  logic clr_q, busy_q, done_q, acc_en;
  logic [SQ_W+WIN_LOG2-1:0] acc;
  assign acc_en = state_q == MEASURE && sym_clk_en_i && !abort_i;
  err_pow_accum #(.WIN_LOG2(WIN_LOG2)) u_acc (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .clr_i   (clr_q),
    .en_i    (acc_en),
    .error_i (error_i),
    .acc_o   (acc)
  );
  // clr_q is high exactly while in CLEAR, so it doubles as the accumulator clear.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q <= '0;
      err_q <= '0;
      err_count_q <= '0;
      mse_q <= '0;
      clr_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      clr_q <= 1'b0;
      done_q <= 1'b0;
      if (abort_i && state_q inside {CLEAR, SETTLE, MEASURE}) begin
        state_q <= IDLE;
        busy_q <= 1'b0;
      end else begin
        case (state_q)
          IDLE: if (start_i && !abort_i) begin
            state_q <= CLEAR;
            clr_q <= 1'b1;
            busy_q <= 1'b1;
          end
          CLEAR: begin
            cnt_q <= '0;
            err_q <= '0;
            state_q <= SETTLE;
          end
          SETTLE: if (sym_clk_en_i) begin
            cnt_q <= cnt_q == SET_LAST ? '0 : cnt_q + CW'(1);
            if (cnt_q == SET_LAST) state_q <= MEASURE;
          end
          MEASURE: if (sym_clk_en_i) begin
            err_q <= err_q + EW'(sym_error_i);
            cnt_q <= cnt_q + CW'(1);
            if (cnt_q == WIN_LAST) state_q <= DONE;
          end
          DONE: begin
            err_count_q <= err_q;
            mse_q <= SQ_W'(acc >> WIN_LOG2);
            done_q <= 1'b1;
            busy_q <= 1'b0;
            state_q <= IDLE;
          end
          default: begin
            state_q <= IDLE;
            busy_q <= 1'b0;
          end
        endcase
      end
    end
  end
  assign clear_accum_o = clr_q;
  assign busy_o = busy_q;
  assign done_o = done_q;
  assign err_count_o = err_count_q;
  assign mean_sq_err_o = mse_q;
endmodule
